updn_counter_mod: RTL and testbench
===================================

# updn_counter_mod

Parametrised up/down counter with runtime modulo limit, programmable step, wrap or saturate boundary mode, synchronous load, and sticky overflow/underflow flags. It generalises the fixed-width load-able up/down counter into a reusable timer/address/sequence generator. It is used wherever a bounded, reloadable count with boundary detection is needed.

## Interface
- WIDTH, 8: count, data_in and limit width (≥2)
- STEP_W, 4: step input width (1 ≤ STEP_W ≤ WIDTH)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable
- ld  in  1  synchronous load of data_in
- U_D  in  1  direction: 1 = up, 0 = down
- data_in  in  WIDTH  load value
- limit  in  WIDTH  inclusive upper bound; legal count range 0..limit
- step  in  STEP_W  increment/decrement magnitude; 0 = hold
- sat  in  1  1 = saturate at bounds, 0 = wrap modulo limit+1
- clr_flags  in  1  synchronous clear of ovf/unf
- count  out  WIDTH  registered count
- tc  out  1  registered one-cycle terminal-count pulse
- ovf  out  1  sticky: upper bound crossed or clamped
- unf  out  1  sticky: lower bound crossed or clamped

## Operation
- Priority per clock: ld > en > hold.
- Load: count <= min(data_in, limit); tc=0; flags unchanged except clr_flags.
- Effective step s = min(step, limit+1), computed in WIDTH+1 bits; all arithmetic in WIDTH+1 bits, no truncation before comparison.
- en=1, count > limit (limit lowered below count): count <= 0 if sat=0, limit if sat=1; tc=1; ovf set. Direction ignored that cycle.
- en=1, U_D=1, sum = count + s:
  - sum ≤ limit: count <= sum, tc=0.
  - sum > limit, sat=0: count <= sum − (limit+1); tc=1; ovf set.
  - sum > limit, sat=1: count <= limit; tc=1; ovf set (also fires while already held at limit with s>0).
- en=1, U_D=0:
  - count ≥ s: count <= count − s, tc=0.
  - count < s, sat=0: count <= count + (limit+1) − s; tc=1; unf set.
  - count < s, sat=1: count <= 0; tc=1; unf set (also while held at 0 with s>0).
- s=0 with en=1: count holds, tc=0, no flag change (unless count > limit rule applies).
- limit=0: count pinned at 0; any nonzero step sets tc and ovf/unf per direction.
- clr_flags: ovf, unf <= 0 next edge; a set event in the same cycle wins (flag ends 1).
- en=0, ld=0: count holds, tc=0.

## Timing
- Reset (async assert, any time including mid-count): count=0, tc=0, ovf=0, unf=0 immediately; deassertion synchronous to clk by the surrounding reset logic.
- All outputs registered; single-cycle latency from en/ld/U_D/step/sat/limit sampled at edge N to count/tc/flags valid after edge N.
- tc is high exactly one cycle per boundary event; consecutive events give tc high on consecutive cycles.
- Direction, step, sat and limit may change every cycle; no pipeline state beyond count and flags.

## Test plan
- Reset mid-count: WIDTH=8, count at 37, assert reset between edges -> count=0, tc=0, ovf=0, unf=0 before next edge, stays 0 while reset high.
- Wrap up: limit=9, sat=0, step=3, load 7, en=1, U_D=1 -> count 7,0,3,6,9,2; tc pulses on the 7->0 and 9->2 transitions; ovf=1.
- Wrap down / saturate down: limit=9, step=4, load 2, U_D=0: sat=0 -> 2,8,4,0,6 with unf=1; repeat with sat=1 -> 2,0,0 with tc high both clamp cycles.
- Load priority and clamp: en=1, ld=1, data_in=200, limit=50 -> count=50, tc=0; next cycle ld=0, U_D=1, step=1, sat=1 -> count=50, tc=1, ovf=1.
- Limit lowered: count=40, set limit=20, sat=0, en=1, U_D=0, step=1 -> count=0, tc=1, ovf=1 (unf unchanged).
- Flag clear race: ovf=1, assert clr_flags alone -> ovf=0; assert clr_flags in same cycle as up-wrap -> ovf=1, tc=1.

Source files
------------

// File: rtl/updn_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module      : updn_counter_mod
//  Description : Up/down counter with runtime modulo limit, programmable step,
//                wrap/saturate boundary mode, load and sticky ovf/unf flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module updn_counter_mod #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ld,
    input  logic              U_D,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [WIDTH-1:0]  limit,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              unf
);

    localparam int EW = WIDTH + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [EW-1:0]    w_cnt;
    logic [EW-1:0]    w_lim;
    logic [EW-1:0]    w_lim1;
    logic [EW-1:0]    w_step;
    logic [EW-1:0]    w_s;
    logic [EW-1:0]    w_sum;
    logic [EW-1:0]    w_next_ext;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;

    assign w_cnt  = {1'b0, r_count};
    assign w_lim  = {1'b0, limit};
    assign w_lim1 = w_lim + EW'(1);
    assign w_step = EW'(step);
    // Step never exceeds the modulus, so one wrap correction always suffices.
    assign w_s    = (w_step < w_lim1) ? w_step : w_lim1;
    assign w_sum  = w_cnt + w_s;

    always_comb begin
        w_next_ext = w_cnt;
        w_tc_nxt   = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        if (ld) begin
            w_next_ext = ({1'b0, data_in} < w_lim) ? {1'b0, data_in} : w_lim;
        end else if (en) begin
            if (w_cnt > w_lim) begin
                w_next_ext = sat ? w_lim : '0;
                w_tc_nxt   = 1'b1;
                w_set_ovf  = 1'b1;
            end else if (U_D) begin
                if (w_sum <= w_lim) begin
                    w_next_ext = w_sum;
                end else begin
                    w_next_ext = sat ? w_lim : (w_sum - w_lim1);
                    w_tc_nxt   = 1'b1;
                    w_set_ovf  = 1'b1;
                end
            end else begin
                if (w_cnt >= w_s) begin
                    w_next_ext = w_cnt - w_s;
                end else begin
                    w_next_ext = sat ? '0 : (w_cnt + w_lim1 - w_s);
                    w_tc_nxt   = 1'b1;
                    w_set_unf  = 1'b1;
                end
            end
        end
    end

    assign w_count_nxt = w_next_ext[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            // A set event in the same cycle as a clear leaves the flag set.
            r_ovf   <= (r_ovf & ~clr_flags) | w_set_ovf;
            r_unf   <= (r_unf & ~clr_flags) | w_set_unf;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_updn_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updn_counter_mod
//  Description : Directed self-checking bench for updn_counter_mod.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updn_counter_mod;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              ld;
    logic              U_D;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  limit;
    logic [STEP_W-1:0] step;
    logic              sat;
    logic              clr_flags;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              unf;

    int tests_run    = 0;
    int tests_failed = 0;

    updn_counter_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ld        (ld),
        .U_D       (U_D),
        .data_in   (data_in),
        .limit     (limit),
        .step      (step),
        .sat       (sat),
        .clr_flags (clr_flags),
        .count     (count),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input int t, input int o, input int u);
        check_val({tag, ".count"}, int'(count), c);
        check_val({tag, ".tc"},    int'(tc),    t);
        check_val({tag, ".ovf"},   int'(ovf),   o);
        check_val({tag, ".unf"},   int'(unf),   u);
    endtask

    task automatic do_load(input int val, input int lim);
        ld = 1'b1; en = 1'b0; clr_flags = 1'b1;
        data_in = WIDTH'(val); limit = WIDTH'(lim);
        tick();
        ld = 1'b0; clr_flags = 1'b0;
    endtask

    int up_seq [5] = '{0, 3, 6, 9, 2};
    int up_tc  [5] = '{1, 0, 0, 0, 1};
    int dn_seq [4] = '{8, 4, 0, 6};
    int dn_tc  [4] = '{1, 0, 0, 1};

    initial begin
        reset = 1'b1; en = 1'b0; ld = 1'b0; U_D = 1'b1; data_in = '0;
        limit = '0; step = '0; sat = 1'b0; clr_flags = 1'b0;
        #12;
        chk("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Wrap up: limit 9, step 3, from 7
        do_load(7, 9);
        chk("up_load", 7, 0, 0, 0);
        en = 1'b1; U_D = 1'b1; step = 4'd3; sat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("up%0d", i), up_seq[i], up_tc[i], 1, 0);
        end

        // Clear alone, then clear racing an up-wrap
        en = 1'b0; clr_flags = 1'b1;
        tick();
        chk("clr_alone", 2, 0, 0, 0);
        clr_flags = 1'b0; en = 1'b1;
        tick();
        chk("race_a", 5, 0, 0, 0);
        tick();
        chk("race_b", 8, 0, 0, 0);
        clr_flags = 1'b1;
        tick();
        chk("race_wrap", 1, 1, 1, 0);
        clr_flags = 1'b0;

        // Wrap down: limit 9, step 4, from 2
        do_load(2, 9);
        en = 1'b1; U_D = 1'b0; step = 4'd4; sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("dn%0d", i), dn_seq[i], dn_tc[i], 0, 1);
        end

        // Saturate down
        do_load(2, 9);
        chk("sdn_load", 2, 0, 0, 0);
        en = 1'b1; U_D = 1'b0; step = 4'd4; sat = 1'b1;
        tick();
        chk("sdn0", 0, 1, 0, 1);
        tick();
        chk("sdn1", 0, 1, 0, 1);

        // Load wins over enable, clamped to limit; then saturate-up at limit
        ld = 1'b1; en = 1'b1; clr_flags = 1'b1; data_in = 8'd200; limit = 8'd50;
        U_D = 1'b1; step = 4'd1; sat = 1'b1;
        tick();
        chk("ld_clamp", 50, 0, 0, 0);
        ld = 1'b0; clr_flags = 1'b0;
        tick();
        chk("sat_up", 50, 1, 1, 0);

        // Limit lowered below count
        do_load(40, 50);
        chk("ll_load", 40, 0, 0, 0);
        limit = 8'd20; sat = 1'b0; en = 1'b1; U_D = 1'b0; step = 4'd1;
        tick();
        chk("lim_low", 0, 1, 1, 0);

        // limit = 0 with nonzero step downward
        do_load(0, 0);
        en = 1'b1; U_D = 1'b0; step = 4'd2; sat = 1'b0;
        tick();
        chk("lim0_dn", 0, 1, 0, 1);

        // Step 0 holds, en=0 holds
        do_load(5, 9);
        en = 1'b1; U_D = 1'b1; step = 4'd0;
        tick();
        chk("step0", 5, 0, 0, 0);
        en = 1'b0; step = 4'd3;
        tick();
        chk("en0", 5, 0, 0, 0);

        // Reset asserted between edges mid-count
        do_load(37, 100);
        chk("rst_pre", 37, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_async", 0, 0, 0, 0);
        en = 1'b1; U_D = 1'b1; step = 4'd1;
        tick();
        chk("rst_hold", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0; en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
